// File: rtl/conv_stream_mc_if.sv
// conv_stream_mc_if: pixel stream, kernel and result bundle of the convolution engine
interface conv_stream_mc_if #(
  parameter int N  = 8,
  parameter int K  = 3,
  parameter int OC = 2
);
  logic                  ce;
  logic signed [N-1:0]   activation;
  logic [OC*K*K*N-1:0]   weights;
  logic [OC*N-1:0]       conv_out;
  logic                  conv_valid;
  logic                  conv_end;
  modport master (output ce, activation, weights, input conv_out, conv_valid, conv_end);
  modport slave  (input ce, activation, weights, output conv_out, conv_valid, conv_end);
endinterface

// File: rtl/conv_stream_mc.sv
// conv_stream_mc: streaming KxK strided convolution over OC channels with saturation and optional ReLU
module conv_stream_mc #(
  parameter int MAP_SIZE = 10,
  parameter int K        = 3,
  parameter int S        = 1,
  parameter int N        = 8,
  parameter int Q        = 4,
  parameter int OC       = 2,
  parameter int RELU     = 1
) (
  input logic             clk,
  input logic             global_rst,
  conv_stream_mc_if.slave bus
);
  localparam int O    = (MAP_SIZE - K) / S + 1;
  localparam int CW   = $clog2(MAP_SIZE);
  localparam int LAST = K - 1 + (O - 1) * S;
  localparam int PW   = 2 * N;
  localparam int AW   = 2 * N + $clog2(K * K);
  localparam int LB   = (K - 1) * MAP_SIZE;
  localparam logic [CW-1:0] MAXC = CW'(MAP_SIZE - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (N - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (N - 1)));

  logic [CW-1:0]        col, row;
  logic signed [N-1:0]  sr [LB];
  logic signed [N-1:0]  col_in [K];
  logic signed [N-1:0]  win [K][K];
  logic signed [N-1:0]  w [OC][K*K];
  logic signed [PW-1:0] prod [OC][K*K];
  logic signed [N-1:0]  res [OC];
  logic [OC*N-1:0]      out_q;
  logic                 v0, e0, v1, e1, v2, e2;
  logic                 emit, last;

  assign emit = int'(row) >= K - 1 && int'(col) >= K - 1 &&
                (int'(row) - (K - 1)) % S == 0 && (int'(col) - (K - 1)) % S == 0;
  assign last = int'(row) == LAST && int'(col) == LAST;

  always_ff @(posedge clk) begin
    if (global_rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.ce) begin
      col <= (col == MAXC) ? '0 : col + 1'b1;
      row <= (col == MAXC) ? ((row == MAXC) ? '0 : row + 1'b1) : row;
    end
  end

  // sr[d*MAP_SIZE-1] is the pixel d rows directly above the incoming one
  for (genvar i = 0; i < K; i++) begin : g_col
    if (i == K - 1) begin : g_new
      assign col_in[i] = bus.activation;
    end else begin : g_old
      assign col_in[i] = sr[(K - 1 - i) * MAP_SIZE - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ce) begin
      sr[0] <= bus.activation;
      for (int n = 1; n < LB; n++) sr[n] <= sr[n-1];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= col_in[i];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < OC; c++)
      for (int t = 0; t < K * K; t++)
        w[c][t] = bus.weights[(c*K*K + t)*N +: N];
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < OC; c++)
      for (int t = 0; t < K * K; t++)
        prod[c][t] <= PW'(win[t/K][t%K]) * PW'(w[c][t]);
  end

  always_comb begin
    for (int c = 0; c < OC; c++) begin
      logic signed [AW-1:0] acc, sh;
      logic signed [N-1:0]  pre;
      acc = '0;
      for (int t = 0; t < K * K; t++) acc = acc + AW'(prod[c][t]);
      sh  = acc >>> Q;
      pre = (sh > MAXV) ? MAXV[N-1:0] : (sh < MINV) ? MINV[N-1:0] : sh[N-1:0];
      res[c] = (RELU != 0 && pre[N-1]) ? '0 : pre;
    end
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      {v0, e0, v1, e1, v2, e2} <= '0;
      out_q <= '0;
    end else begin
      v0 <= bus.ce & emit;
      e0 <= bus.ce & emit & last;
      v1 <= v0;
      e1 <= e0;
      v2 <= v1;
      e2 <= e1;
      if (v1)
        for (int c = 0; c < OC; c++) out_q[c*N +: N] <= res[c];
    end
  end

  assign bus.conv_out   = out_q;
  assign bus.conv_valid = v2;
  assign bus.conv_end   = e2;
endmodule

// File: tb/tb_conv_stream_mc.sv
// tb_conv_stream_mc: scoreboard bench driving three configurations (S1/ReLU, S1/no ReLU, S2/ReLU) in lockstep
module tb_conv_stream_mc;
  localparam int MAP = 10, K = 3, N = 8, Q = 4, OC = 2;
  localparam int WW = OC * K * K * N;
  localparam int OW = OC * N;

  typedef struct {
    logic [OW-1:0] out;
    logic          last;
    int            due;
    int            idx;
  } exp_t;

  logic clk = 0, rst = 0, ce = 0;
  logic signed [N-1:0] act = '0;
  logic [WW-1:0] wts = '0;
  int cyc = 0, total = 0, bad = 0, pr = 0, pc = 0;
  int vcnt [3], ecnt [3], first_idx [3];
  bit started = 0;
  logic signed [N-1:0] img [MAP][MAP];
  exp_t q0 [$], q1 [$], q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_stream_mc_if #(.N(N), .K(K), .OC(OC)) b0 ();
  conv_stream_mc_if #(.N(N), .K(K), .OC(OC)) b1 ();
  conv_stream_mc_if #(.N(N), .K(K), .OC(OC)) b2 ();
  assign b0.ce = ce; assign b0.activation = act; assign b0.weights = wts;
  assign b1.ce = ce; assign b1.activation = act; assign b1.weights = wts;
  assign b2.ce = ce; assign b2.activation = act; assign b2.weights = wts;

  conv_stream_mc #(.MAP_SIZE(MAP), .K(K), .S(1), .N(N), .Q(Q), .OC(OC), .RELU(1))
    d0 (.clk(clk), .global_rst(rst), .bus(b0));
  conv_stream_mc #(.MAP_SIZE(MAP), .K(K), .S(1), .N(N), .Q(Q), .OC(OC), .RELU(0))
    d1 (.clk(clk), .global_rst(rst), .bus(b1));
  conv_stream_mc #(.MAP_SIZE(MAP), .K(K), .S(2), .N(N), .Q(Q), .OC(OC), .RELU(1))
    d2 (.clk(clk), .global_rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_out(input int r, input int c, input int relu);
    logic [OW-1:0] res;
    logic signed [N-1:0] wv;
    longint acc, sh;
    res = '0;
    for (int ch = 0; ch < OC; ch++) begin
      acc = 0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          wv = wts[((ch*K*K) + (i*K + j))*N +: N];
          acc += longint'(img[r-K+1+i][c-K+1+j]) * longint'(wv);
        end
      sh = acc >>> Q;
      if (sh > 127) sh = 127;
      if (sh < -128) sh = -128;
      if (relu != 0 && sh < 0) sh = 0;
      res[ch*N +: N] = sh[N-1:0];
    end
    return res;
  endfunction

  task automatic accept(input logic signed [N-1:0] a, input int e);
    exp_t x;
    int s, o, lst;
    img[pr][pc] = a;
    for (int k = 0; k < 3; k++) begin
      s = (k == 2) ? 2 : 1;
      o = (MAP - K) / s + 1;
      lst = K - 1 + (o - 1) * s;
      if (pr >= K-1 && pc >= K-1 && (pr-K+1) % s == 0 && (pc-K+1) % s == 0) begin
        x.out = ref_out(pr, pc, (k == 1) ? 0 : 1);
        x.last = (pr == lst && pc == lst);
        x.due = e + 3;
        x.idx = pr * MAP + pc;
        case (k)
          0: q0.push_back(x);
          1: q1.push_back(x);
          default: q2.push_back(x);
        endcase
      end
    end
    pc = (pc == MAP-1) ? 0 : pc + 1;
    if (pc == 0) pr = (pr == MAP-1) ? 0 : pr + 1;
  endtask

  task automatic chk(input int k, input logic v, input logic e, input logic [OW-1:0] o);
    exp_t x;
    int n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (n > 0)
      case (k)
        0: x = q0[0];
        1: x = q1[0];
        default: x = q2[0];
      endcase
    if (v === 1'b1 || (n > 0 && x.due <= cyc)) begin
      if (n > 0)
        case (k)
          0: void'(q0.pop_front());
          1: void'(q1.pop_front());
          default: void'(q2.pop_front());
        endcase
      total++;
      assert (v === 1'b1 && n > 0) else begin
        bad++;
        $error("FAIL valid_event dut%0d valid=%b pending=%0d cyc=%0d", k, v, n, cyc);
      end
      if (v === 1'b1 && n > 0) begin
        if (vcnt[k] == 0) first_idx[k] = x.idx;
        vcnt[k]++;
        ecnt[k] += int'(e);
        check($sformatf("out_dut%0d_px%0d", k, x.idx), 32'(o), 32'(x.out));
        check($sformatf("end_dut%0d_px%0d", k, x.idx), 32'(e), 32'(x.last));
        check($sformatf("latency_dut%0d_px%0d", k, x.idx), cyc, x.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk(0, b0.conv_valid, b0.conv_end, b0.conv_out);
      chk(1, b1.conv_valid, b1.conv_end, b1.conv_out);
      chk(2, b2.conv_valid, b2.conv_end, b2.conv_out);
    end
  end

  task automatic step(input logic c, input logic signed [N-1:0] a);
    ce = c;
    act = a;
    @(posedge clk);
    #1;
    if (rst) begin
      pr = 0; pc = 0;
      q0.delete(); q1.delete(); q2.delete();
    end else if (c) accept(a, cyc - 1);
  endtask

  task automatic do_reset(input logic c);
    rst = 1;
    step(c, 8'sh33);
    rst = 0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 3; k++) begin
      vcnt[k] = 0; ecnt[k] = 0; first_idx[k] = -1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out0"}, 32'(b0.conv_out), 0);
    check({tag, "_out1"}, 32'(b1.conv_out), 0);
    check({tag, "_out2"}, 32'(b2.conv_out), 0);
    check({tag, "_val"}, {29'd0, b0.conv_valid, b1.conv_valid, b2.conv_valid}, 0);
    check({tag, "_end"}, {29'd0, b0.conv_end, b1.conv_end, b2.conv_end}, 0);
  endtask

  // mode 0: constant v, mode 1: raster index mod 16, mode 2: random
  task automatic frame(input int mode, input logic signed [N-1:0] v, input bit ragged);
    logic c;
    logic signed [N-1:0] p;
    for (int i = 0; i < MAP * MAP; i++) begin
      p = (mode == 0) ? v : (mode == 1) ? N'(i % 16) : N'($urandom);
      do begin
        c = ragged ? 1'($urandom_range(0, 1)) : 1'b1;
        step(c, p);
      end while (!c);
    end
  endtask

  task automatic drain();
    repeat (5) step(1'b0, '0);
  endtask

  task automatic set_identity();
    wts = '0;
    wts[4*N +: N] = 8'h10;
    for (int t = 0; t < K*K; t++) wts[(K*K + t)*N +: N] = 8'h02;
  endtask

  initial begin
    clear_counts();
    #2;
    do_reset(1'b1);
    do_reset(1'b0);
    started = 1;
    check_zero("reset");

    set_identity();
    clear_counts();
    frame(0, 8'sh10, 0);
    drain();
    check("ident_valids", vcnt[0], 64);
    check("ident_ends", ecnt[0], 1);
    check("ident_first_px", first_idx[0], 22);
    check("ident_value", 32'(b0.conv_out), 32'h1210);

    for (int t = 0; t < K*K; t++) begin
      wts[t*N +: N] = 8'h10;
      wts[(K*K + t)*N +: N] = 8'hF0;
    end
    frame(0, 8'sh70, 0);
    drain();
    check("sat_relu", 32'(b0.conv_out), 32'h007F);
    check("sat_norelu", 32'(b1.conv_out), 32'h807F);

    wts = '0;
    wts[4*N +: N] = 8'h10;
    wts[(K*K + 4)*N +: N] = 8'h10;
    clear_counts();
    frame(1, '0, 0);
    drain();
    check("stride_valids", vcnt[2], 16);
    check("stride_ends", ecnt[2], 1);
    check("stride_last", 32'(b2.conv_out), 32'h0D0D);

    set_identity();
    clear_counts();
    frame(0, 8'sh10, 1);
    drain();
    check("ragged_valids", vcnt[0], 64);
    check("ragged_value", 32'(b0.conv_out), 32'h1210);

    for (int i = 0; i < 47; i++) step(1'b1, 8'sh10);
    do_reset(1'b1);
    check_zero("midrst");
    for (int t = 0; t < OC*K*K; t++) wts[t*N +: N] = N'($urandom_range(0, 48) - 24);
    clear_counts();
    frame(2, '0, 0);
    drain();
    check("midrst_valids", vcnt[0], 64);
    check("midrst_ends", ecnt[0], 1);

    clear_counts();
    frame(2, '0, 0);
    frame(2, '0, 0);
    frame(2, '0, 0);
    drain();
    check("b2b_valids0", vcnt[0], 192);
    check("b2b_ends0", ecnt[0], 3);
    check("b2b_valids2", vcnt[2], 48);
    check("b2b_ends2", ecnt[2], 3);
    check("pending", q0.size() + q1.size() + q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
